// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: oversamples ps2_clk/ps2_data, deframes 11-bit
// frames and buffers valid scan-code bytes in a small FIFO with a pop handshake.
module ps2_keyboard_rx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       ready,
  input  logic       nextdata_n,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STOP_COUNT = CNT_W'(10);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [9:0]             buffer;
  logic [CNT_W-1:0]       count;
  logic [7:0]             fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]       w_ptr;
  logic [PTR_W-1:0]       r_ptr;

  logic fall_c;
  logic frame_ok_c;
  logic wr_c;
  logic pop_c;

  // Falling edge seen on the two oldest synchronizer stages
  assign fall_c     = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  // Start low, stop high, odd parity over data+parity
  assign frame_ok_c = ~buffer[0] & ps2_data & (^buffer[9:1]);
  assign wr_c       = fall_c && (count == STOP_COUNT) && frame_ok_c;
  assign pop_c      = ready & ~nextdata_n;
  assign data       = fifo[r_ptr];

  // ps2_clk synchronizer / edge-detect chain (no reset needed)
  always_ff @(posedge clk) begin
    clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
  end

  // Bit counter and frame shift buffer, one step per ps2_clk falling edge
  always_ff @(posedge clk) begin
    if (!clrn) begin
      count <= '0;
    end else if (fall_c) begin
      if (count == STOP_COUNT) begin
        count <= '0;
      end else begin
        buffer[count] <= ps2_data;
        count         <= count + CNT_W'(1);
      end
    end
  end

  // FIFO storage write; contents survive reset
  always_ff @(posedge clk) begin
    if (clrn && wr_c) begin
      fifo[w_ptr] <= buffer[8:1];
    end
  end

  // Pointers, ready and sticky overflow; a write wins over a same-cycle pop for ready
  always_ff @(posedge clk) begin
    if (!clrn) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      ready    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (pop_c) begin
        r_ptr <= r_ptr + PTR_W'(1);
      end
      if (wr_c) begin
        w_ptr <= w_ptr + PTR_W'(1);
        ready <= 1'b1;
        if (r_ptr == w_ptr + PTR_W'(1)) begin
          overflow <= 1'b1;
        end
      end else if (pop_c && (w_ptr == r_ptr + PTR_W'(1))) begin
        ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed scenarios plus randomized frames/pops
// checked against a queue-based model of the receive FIFO.
module tb_ps2_keyboard_rx;

  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned SYNC_STAGES = 3;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: bytes visible to the consumer, oldest first
  byte unsigned q[$];
  bit           m_over;

  // Monitor for the hold-pop scenario
  bit         mon_en = 1'b0;
  int         ready_hi = 0;
  logic [7:0] hold_data = 8'h00;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data      (data),
    .ready     (ready),
    .nextdata_n(nextdata_n),
    .overflow  (overflow)
  );

  always @(negedge clk) begin
    if (mon_en && ready === 1'b1) begin
      ready_hi++;
      hold_data = data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".ready"}, 32'(ready), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, ".data"}, 32'(data), 32'(q[0]));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_over));
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_start,
                                             input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f[0]   = bad_start;
    f[8:1] = b;
    f[9]   = ~(^b) ^ bad_par;
    f[10]  = ~bad_stop;
    return f;
  endfunction

  function automatic bit frame_valid(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
  endfunction

  task automatic model_push(input logic [10:0] f);
    if (frame_valid(f)) begin
      if (q.size() == FIFO_DEPTH - 1) m_over = 1'b1;
      q.push_back(f[8:1]);
    end
  endtask

  // Drive nbits of a frame, LSB first, with random PS/2 half-periods
  task automatic send_bits(input logic [10:0] f, input int nbits, input bit chk_lat);
    int h;
    for (int i = 0; i < nbits; i++) begin
      h = int'($urandom_range(3, 7));
      ps2_data = f[i];
      cycles(h);
      ps2_clk = 1'b0;
      if (chk_lat && i == 10) begin
        cycles(SYNC_STAGES - 1);
        chk("latency.before", 32'(ready), 32'd0);
        cycles(1);
        chk("latency.after", 32'(ready), 32'd1);
        cycles(1);
      end else begin
        cycles(h);
      end
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 11, 1'b0);
    cycles(4);
    model_push(f);
  endtask

  task automatic pop_one(input string tag);
    nextdata_n = 1'b0;
    cycles(1);
    nextdata_n = 1'b1;
    if (q.size() != 0) void'(q.pop_front());
    cycles(1);
    check_state(tag);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    cycles(2);
    clrn = 1'b1;
    q.delete();
    m_over = 1'b0;
    cycles(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    int          kind;
    clrn       = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    m_over     = 1'b0;
    cycles(5);
    clrn = 1'b1;
    q.delete();
    cycles(1);
    check_state("reset");

    // Single frame 0x1C, with stop-bit latency check
    f = make_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_bits(f, 11, 1'b1);
    cycles(4);
    model_push(f);
    check_state("t1");
    chk("t1.byte", 32'(data), 32'h1C);
    pop_one("t1.pop");

    // Two bytes, popped in order
    send_frame(make_frame(8'hF0, 1'b0, 1'b0, 1'b0));
    send_frame(make_frame(8'h1C, 1'b0, 1'b0, 1'b0));
    check_state("t2");
    chk("t2.byte", 32'(data), 32'hF0);
    pop_one("t2.pop1");
    pop_one("t2.pop2");

    // Bad parity dropped, next valid frame accepted
    send_frame(make_frame(8'h1C, 1'b0, 1'b1, 1'b0));
    check_state("t3.badpar");
    send_frame(make_frame(8'h32, 1'b0, 1'b0, 1'b0));
    check_state("t3.good");
    chk("t3.byte", 32'(data), 32'h32);
    pop_one("t3.pop");

    // Fill to FIFO_DEPTH without popping: overflow on the last write
    for (int i = 1; i <= FIFO_DEPTH; i++) begin
      send_frame(make_frame(8'(i), 1'b0, 1'b0, 1'b0));
      check_state($sformatf("t4.fill%0d", i));
    end
    chk("t4.overflow", 32'(overflow), 32'd1);
    do_reset();
    check_state("t4.reset");

    // Pop held low: byte visible for exactly one cycle
    ready_hi   = 0;
    mon_en     = 1'b1;
    nextdata_n = 1'b0;
    send_bits(make_frame(8'h5A, 1'b0, 1'b0, 1'b0), 11, 1'b0);
    cycles(4);
    nextdata_n = 1'b1;
    mon_en     = 1'b0;
    chk("t5.ready_cycles", 32'(ready_hi), 32'd1);
    chk("t5.byte", 32'(hold_data), 32'h5A);
    check_state("t5");

    // Reset in the middle of a frame
    send_bits(make_frame(8'h66, 1'b0, 1'b0, 1'b0), 5, 1'b0);
    do_reset();
    send_frame(make_frame(8'h66, 1'b0, 1'b0, 1'b0));
    check_state("t6");
    chk("t6.byte", 32'(data), 32'h66);
    pop_one("t6.pop");

    // Randomized frames, framing errors and pops
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 3 || q.size() == FIFO_DEPTH) begin
        pop_one($sformatf("rnd%0d.pop", n));
      end else begin
        kind = int'($urandom_range(0, 7));
        f = make_frame(8'($urandom), kind == 0, kind == 1, kind == 2);
        send_frame(f);
        check_state($sformatf("rnd%0d.rx", n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
